// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of a single-port data memory.
// Round-robin grant, latched command, fixed IDLE -> ACCESS -> RESP sequence.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_memWrite,
    output logic              mem_memRead,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_readData,

    output logic              busy,
    output logic              grant_dma
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                grant_dma_q, grant_dma_d;
    logic                last_dma_q, last_dma_d;
    logic                sel_dma;

    // On a tie the requester that did not win last time gets the slot.
    assign sel_dma = dma_req && (!cpu_req || !last_dma_q);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        grant_dma_d = grant_dma_q;
        last_dma_d  = last_dma_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_dma_d = sel_dma;
                    last_dma_d  = sel_dma;
                    we_d        = sel_dma ? dma_we    : cpu_we;
                    addr_d      = sel_dma ? dma_addr  : cpu_addr;
                    wdata_d     = sel_dma ? dma_wdata : cpu_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = mem_readData;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            grant_dma_q <= 1'b0;
            last_dma_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            grant_dma_q <= grant_dma_d;
            last_dma_q  <= last_dma_d;
        end
    end

    // Outputs decode straight from state so reset silences them at once.
    assign mem_memWrite  = (state_q == ACCESS) &&  we_q;
    assign mem_memRead   = (state_q == ACCESS) && !we_q;
    assign mem_address   = addr_q;
    assign mem_writeData = wdata_q;

    assign cpu_ack   = (state_q == RESP) && !grant_dma_q;
    assign dma_ack   = (state_q == RESP) &&  grant_dma_q;
    assign cpu_rdata = (cpu_ack && !we_q) ? rdata_q : '0;
    assign dma_rdata = (dma_ack && !we_q) ? rdata_q : '0;

    assign busy      = (state_q != IDLE);
    assign grant_dma = grant_dma_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a 16-word memory model behind the
// arbiter, hand-computed expectations, one printed line per comparison.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [63:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_memWrite, mem_memRead;
    logic [63:0] mem_address, mem_writeData, mem_readData;
    logic        busy, grant_dma;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_readData(mem_readData),
        .busy(busy), .grant_dma(grant_dma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word-indexed, async read, write at posedge.
    logic [63:0] mem [0:15];
    logic        tb_wr;
    logic [3:0]  tb_idx;
    logic [63:0] tb_val;

    always @(posedge clk) begin
        if (tb_wr)
            mem[tb_idx] <= tb_val;
        else if (mem_memWrite)
            mem[mem_address[6:3]] <= mem_writeData;
    end
    assign mem_readData = mem[mem_address[6:3]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, obs);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [63:0] val);
        tb_wr  = 1'b1;
        tb_idx = idx;
        tb_val = val;
        @(posedge clk);
        #1 tb_wr = 1'b0;
    endtask

    // One isolated transaction; called at a negedge with the arbiter idle.
    task automatic do_single(input bit is_dma, input bit we, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [63:0] exp_rd,
                             input string tag);
        int n, wr, rd;
        bit got;
        logic [63:0] seen_addr, rdata, other_rd;
        logic other_ack;
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        n = 0; wr = 0; rd = 0; got = 1'b0; seen_addr = '0;
        rdata = '0; other_rd = '0; other_ack = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (mem_memWrite) wr++;
            if (mem_memRead)  rd++;
            if (mem_memWrite || mem_memRead) seen_addr = mem_address;
            if (is_dma ? dma_ack : cpu_ack) begin
                got       = 1'b1;
                rdata     = is_dma ? dma_rdata : cpu_rdata;
                other_rd  = is_dma ? cpu_rdata : dma_rdata;
                other_ack = is_dma ? cpu_ack   : dma_ack;
            end
        end
        chk({tag, "_latency"}, 64'(n), 64'd2);
        chk({tag, "_wr_cycles"}, 64'(wr), we ? 64'd1 : 64'd0);
        chk({tag, "_rd_cycles"}, 64'(rd), we ? 64'd0 : 64'd1);
        chk({tag, "_mem_addr"}, seen_addr, addr);
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_other"}, {other_rd[62:0], other_ack}, 64'd0);
        chk({tag, "_grant"}, 64'(grant_dma), 64'(is_dma));
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cpu_t, dma_t, k, last_n, overlap, seen_ack;
        reset = 1'b1; tb_wr = 1'b0; tb_idx = '0; tb_val = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < 16; i++) preload(4'(i), 64'd0);
        preload(4'd1, 64'd42);
        preload(4'd2, 64'd99);
        preload(4'd3, 64'd5);
        @(negedge clk);
        chk("reset_outputs", {59'd0, busy, cpu_ack, dma_ack, mem_memWrite, mem_memRead}, 64'd0);
        chk("reset_rdata", cpu_rdata | dma_rdata, 64'd0);
        chk("reset_grant", 64'(grant_dma), 64'd0);
        reset = 1'b0;

        // CPU store then load, plus a wide address passing through untouched
        do_single(1'b0, 1'b1, 64'h0, 64'd15, 64'd0, "cpu_st0");
        chk("mem0_after_store", mem[0], 64'd15);
        do_single(1'b0, 1'b0, 64'h0, 64'd0, 64'd15, "cpu_ld0");
        do_single(1'b0, 1'b0, 64'hFFFF_FFFF_0000_0008, 64'd0, 64'd42, "cpu_ld_hi");
        do_single(1'b1, 1'b0, 64'h10, 64'd0, 64'd99, "dma_ld10");

        // Reset clears grant_dma immediately
        reset = 1'b1;
        #2;
        chk("rst_grant_clear", 64'(grant_dma), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Simultaneous request after reset: CPU first, DMA 3 cycles later
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h0;
        dma_req = 1; dma_we = 0; dma_addr = 64'h8;
        cpu_t = 0; dma_t = 0;
        for (int n = 1; n <= 12 && dma_t == 0; n++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cpu_t = n;
                chk("tie_cpu_rdata", cpu_rdata, 64'd15);
                chk("tie_cpu_grant", 64'(grant_dma), 64'd0);
                cpu_req = 0;
            end
            if (dma_ack) begin
                dma_t = n;
                chk("tie_dma_rdata", dma_rdata, 64'd42);
                chk("tie_dma_grant", 64'(grant_dma), 64'd1);
                dma_req = 0;
            end
        end
        chk("tie_cpu_ack_time", 64'(cpu_t), 64'd2);
        chk("tie_dma_ack_time", 64'(dma_t), 64'd5);
        @(negedge clk);

        // Continuous contention: strictly alternating, 3-cycle spacing
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h0;
        dma_req = 1; dma_we = 0; dma_addr = 64'h8;
        k = 0; last_n = 0; overlap = 0;
        for (int n = 1; n <= 40 && k < 6; n++) begin
            @(negedge clk);
            if (cpu_ack && dma_ack) overlap++;
            if (cpu_ack || dma_ack) begin
                chk($sformatf("rr_owner_%0d", k), 64'(dma_ack), 64'(k % 2));
                if (k > 0) chk($sformatf("rr_gap_%0d", k), 64'(n - last_n), 64'd3);
                last_n = n;
                k++;
                if (k == 6) begin
                    cpu_req = 0;
                    dma_req = 0;
                end
            end
        end
        chk("rr_count", 64'(k), 64'd6);
        chk("rr_overlap", 64'(overlap), 64'd0);
        @(negedge clk);

        // Address changed during ACCESS must not affect the transaction
        dma_req = 1; dma_we = 0; dma_addr = 64'h8;
        @(negedge clk);
        chk("chg_access_read", 64'(mem_memRead), 64'd1);
        dma_addr = 64'h10;
        @(negedge clk);
        chk("chg_ack", 64'(dma_ack), 64'd1);
        chk("chg_rdata", dma_rdata, 64'd42);
        dma_req = 0;
        @(negedge clk);

        // Reset in the middle of a CPU store to 0x18
        cpu_req = 1; cpu_we = 1; cpu_addr = 64'h18; cpu_wdata = 64'd77;
        @(posedge clk);
        #1;
        chk("abort_in_access", 64'(mem_memWrite), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_quiet", {61'd0, busy, mem_memWrite, cpu_ack}, 64'd0);
        cpu_req = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_mem18", mem[3], 64'd5);
        seen_ack = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) seen_ack++;
        end
        chk("abort_no_ack", 64'(seen_ack), 64'd0);
        do_single(1'b0, 1'b1, 64'h18, 64'd77, 64'd0, "post_st18");
        do_single(1'b0, 1'b0, 64'h18, 64'd0, 64'd77, "post_ld18");

        // Idle stability
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk($sformatf("idle_%0d", n),
                {59'd0, busy, cpu_ack, dma_ack, mem_memWrite, mem_memRead}, 64'd0);
        end
        chk("idle_grant", 64'(grant_dma), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
